// File: rtl/yazmac_obegi_skorbord.sv
// +--------------------------------------------------------------------------+
// | yazmac_obegi_skorbord : register file with per-register in-flight       |
// | write scoreboard, write-through read bypass and RAW stall generation    |
// | Revision 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module yazmac_obegi_skorbord #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int N_OKU  = 2,
  parameter int PEND_W = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_OKU*AW-1:0]     oku_adres_i,
  input  logic [N_OKU-1:0]        oku_gecerli_i,
  output logic [N_OKU*XLEN-1:0]   oku_deger_o,
  input  logic                    yrt_gonder_i,
  input  logic [AW-1:0]           yrt_rd_adres_i,
  input  logic                    yrt_rd_yaz_i,
  input  logic                    yrt_iptal_i,
  input  logic [AW-1:0]           yrt_iptal_adres_i,
  input  logic                    gy_yaz_yazmac_i,
  input  logic [AW-1:0]           gy_yaz_adres_i,
  input  logic [XLEN-1:0]         gy_yaz_deger_i,
  output logic                    ddb_durdur_o,
  output logic                    sb_hata_o,
  output logic [31:0]             durdur_sayac_o
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [XLEN-1:0]   regs_q [NREG];
  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic              hata_q, hata_d;
  logic [31:0]       sayac_q, sayac_d;

  logic [NREG-1:0]   peff_nz;
  logic [N_OKU-1:0]  oku_blok;
  logic              rd_dolu;
  logic              kabul;

  // A writeback landing this cycle retires one in-flight write before the stall check.
  always_comb begin
    peff_nz = '0;
    for (int r = 1; r < NREG; r++) begin
      if (gy_yaz_yazmac_i && gy_yaz_adres_i == AW'(r))
        peff_nz[r] = (pend_q[r] > PEND_W'(1));
      else
        peff_nz[r] = (pend_q[r] != '0);
    end
  end

  for (genvar k = 0; k < N_OKU; k++) begin : g_oku
    logic [AW-1:0] adr;
    assign adr = oku_adres_i[k*AW +: AW];
    assign oku_deger_o[k*XLEN +: XLEN] =
        (adr == '0) ? '0 :
        (gy_yaz_yazmac_i && gy_yaz_adres_i == adr) ? gy_yaz_deger_i : regs_q[adr];
    assign oku_blok[k] = oku_gecerli_i[k] && (adr != '0) && peff_nz[adr];
  end

  assign rd_dolu      = yrt_rd_yaz_i && (yrt_rd_adres_i != '0) && (pend_q[yrt_rd_adres_i] == PEND_MAX);
  assign ddb_durdur_o = yrt_gonder_i && ((|oku_blok) || rd_dolu);
  assign kabul        = yrt_gonder_i && !ddb_durdur_o;

  always_comb begin
    logic              inc, wr, ip, err;
    logic [PEND_W:0]   up_v, dn_v, diff_v;
    hata_d = hata_q;
    pend_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      inc    = kabul && yrt_rd_yaz_i && (yrt_rd_adres_i == AW'(r));
      wr     = gy_yaz_yazmac_i && (gy_yaz_adres_i == AW'(r));
      ip     = yrt_iptal_i && (yrt_iptal_adres_i == AW'(r));
      up_v   = {1'b0, pend_q[r]} + {{PEND_W{1'b0}}, inc};
      dn_v   = {{PEND_W{1'b0}}, wr} + {{PEND_W{1'b0}}, ip};
      diff_v = up_v - dn_v;
      err    = ((wr || ip) && pend_q[r] == '0) || (up_v < dn_v);
      if (up_v < dn_v)
        pend_d[r] = '0;
      else if (diff_v > {1'b0, PEND_MAX})
        pend_d[r] = PEND_MAX;
      else
        pend_d[r] = diff_v[PEND_W-1:0];
      if (err)
        hata_d = 1'b1;
    end
  end

  assign sayac_d = (ddb_durdur_o && sayac_q != 32'hFFFF_FFFF) ? sayac_q + 32'd1 : sayac_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
      hata_q  <= 1'b0;
      sayac_q <= '0;
    end else begin
      if (gy_yaz_yazmac_i && gy_yaz_adres_i != '0)
        regs_q[gy_yaz_adres_i] <= gy_yaz_deger_i;
      pend_q  <= pend_d;
      hata_q  <= hata_d;
      sayac_q <= sayac_d;
    end
  end

  assign sb_hata_o      = hata_q;
  assign durdur_sayac_o = sayac_q;

endmodule

`default_nettype wire

// File: tb/tb_yazmac_obegi_skorbord.sv
// +--------------------------------------------------------------------------+
// | tb_yazmac_obegi_skorbord : directed bench with a reference model        |
// | Revision 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_yazmac_obegi_skorbord;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NOKU = 3;
  localparam int PW   = 2;
  localparam int AW   = 5;
  localparam int PMAX = 3;

  logic                 clk;
  logic                 rst;
  logic [NOKU*AW-1:0]   oku_adres;
  logic [NOKU-1:0]      oku_gecerli;
  logic [NOKU*XLEN-1:0] oku_deger;
  logic                 gonder;
  logic [AW-1:0]        rd_adres;
  logic                 rd_yaz;
  logic                 iptal;
  logic [AW-1:0]        iptal_adres;
  logic                 gy_yaz;
  logic [AW-1:0]        gy_adres;
  logic [XLEN-1:0]      gy_deger;
  logic                 durdur;
  logic                 hata;
  logic [31:0]          sayac;

  yazmac_obegi_skorbord #(
    .XLEN(XLEN), .NREG(NREG), .N_OKU(NOKU), .PEND_W(PW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .oku_adres_i(oku_adres), .oku_gecerli_i(oku_gecerli), .oku_deger_o(oku_deger),
    .yrt_gonder_i(gonder), .yrt_rd_adres_i(rd_adres), .yrt_rd_yaz_i(rd_yaz),
    .yrt_iptal_i(iptal), .yrt_iptal_adres_i(iptal_adres),
    .gy_yaz_yazmac_i(gy_yaz), .gy_yaz_adres_i(gy_adres), .gy_yaz_deger_i(gy_deger),
    .ddb_durdur_o(durdur), .sb_hata_o(hata), .durdur_sayac_o(sayac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: architectural values and outstanding-write counts per register.
  int unsigned m_reg  [NREG];
  int          m_pend [NREG];
  bit          m_hata;
  int unsigned m_sayac;
  bit          model_ok = 1'b0;

  function automatic int adr_of(int k);
    return int'(oku_adres[k*AW +: AW]);
  endfunction

  function automatic bit exp_stall();
    int a, p;
    if (!gonder) return 1'b0;
    for (int k = 0; k < NOKU; k++) begin
      a = adr_of(k);
      if (oku_gecerli[k] && a != 0) begin
        p = m_pend[a];
        if (gy_yaz && int'(gy_adres) == a && p != 0) p = p - 1;
        if (p != 0) return 1'b1;
      end
    end
    if (rd_yaz && rd_adres != 0 && m_pend[rd_adres] == PMAX) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_read(int k);
    int a;
    a = adr_of(k);
    if (a == 0) return 32'd0;
    if (gy_yaz && int'(gy_adres) == a) return gy_deger;
    return m_reg[a];
  endfunction

  always @(posedge clk) begin
    bit st, acc;
    int inc, wr, ip, n;
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_reg[r]  = 0;
        m_pend[r] = 0;
      end
      m_hata   = 1'b0;
      m_sayac  = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      st  = exp_stall();
      acc = gonder && !st;
      for (int r = 1; r < NREG; r++) begin
        inc = (acc && rd_yaz && int'(rd_adres) == r) ? 1 : 0;
        wr  = (gy_yaz && int'(gy_adres) == r) ? 1 : 0;
        ip  = (iptal && int'(iptal_adres) == r) ? 1 : 0;
        n   = m_pend[r] + inc - wr - ip;
        if (((wr + ip) > 0 && m_pend[r] == 0) || n < 0) m_hata = 1'b1;
        m_pend[r] = (n < 0) ? 0 : ((n > PMAX) ? PMAX : n);
      end
      if (gy_yaz && gy_adres != 0) m_reg[gy_adres] = gy_deger;
      if (st && m_sayac != 32'hFFFF_FFFF) m_sayac = m_sayac + 1;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < NOKU; k++)
        check($sformatf("oku_deger[%0d]", k), 64'(oku_deger[k*XLEN +: XLEN]), 64'(exp_read(k)));
      check("ddb_durdur", 64'(durdur), 64'(exp_stall()));
      check("sb_hata", 64'(hata), 64'(m_hata));
      check("durdur_sayac", 64'(sayac), 64'(m_sayac));
    end
  end

  task automatic idle();
    rst = 1'b0; gonder = 1'b0; rd_adres = '0; rd_yaz = 1'b0;
    iptal = 1'b0; iptal_adres = '0; gy_yaz = 1'b0; gy_adres = '0; gy_deger = '0;
    oku_adres = '0; oku_gecerli = '0;
  endtask

  task automatic rd_port(int k, int a);
    oku_adres[k*AW +: AW] = AW'(a);
    oku_gecerli[k] = 1'b1;
  endtask

  task automatic issue(int rd);
    gonder = 1'b1; rd_adres = AW'(rd); rd_yaz = 1'b1;
  endtask

  task automatic gy(int a, logic [31:0] v);
    gy_yaz = 1'b1; gy_adres = AW'(a); gy_deger = v;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic next();
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    settle();
    check("reset sayac", 64'(sayac), 64'd0);
    check("reset hata", 64'(hata), 64'd0);
    next();

    // Basic write, bypass, and register zero.
    gy(5, 32'h1234); rd_port(0, 5);
    settle(); check("bypass x5", 64'(oku_deger[31:0]), 64'h1234);
    next();
    rd_port(0, 5);
    settle(); check("read x5", 64'(oku_deger[31:0]), 64'h1234);
    check("hata unissued write", 64'(hata), 64'd1);
    next();
    gy(0, 32'hFFFF); rd_port(1, 0);
    settle(); check("bypass x0", 64'(oku_deger[63:32]), 64'd0);
    next();
    rd_port(1, 0);
    settle(); check("read x0", 64'(oku_deger[63:32]), 64'd0);
    next();
    rst = 1'b1;
    next();

    // RAW stall then writeback bypass release.
    issue(7);
    settle(); check("issue x7 no stall", 64'(durdur), 64'd0);
    next();
    gonder = 1'b1; rd_port(0, 7);
    settle(); check("stall x7", 64'(durdur), 64'd1);
    next();
    gonder = 1'b1; rd_port(0, 7); gy(7, 32'hAB);
    settle();
    check("x7 released", 64'(durdur), 64'd0);
    check("x7 bypass", 64'(oku_deger[31:0]), 64'hAB);
    check("sayac after stall", 64'(sayac), 64'd1);
    next();
    settle(); check("hata clean", 64'(hata), 64'd0);

    // Pending counter saturation.
    for (int i = 0; i < 3; i++) begin
      issue(3);
      next();
    end
    issue(3);
    settle(); check("x3 full stall", 64'(durdur), 64'd1);
    next();
    for (int i = 0; i < 3; i++) begin
      gy(3, 32'h33);
      next();
    end
    gonder = 1'b1; rd_port(0, 3);
    settle();
    check("x3 drained", 64'(durdur), 64'd0);
    check("x3 value", 64'(oku_deger[31:0]), 64'h33);
    check("x3 hata", 64'(hata), 64'd0);
    next();

    // Issue and writeback to the same register in one cycle.
    issue(9);
    next();
    issue(9); gy(9, 32'h99);
    next();
    gonder = 1'b1; rd_port(1, 9);
    settle();
    check("x9 still pending", 64'(durdur), 64'd1);
    check("x9 hata", 64'(hata), 64'd0);
    next();
    gy(9, 32'h9A);
    next();

    // Squash, then a spurious squash.
    issue(4);
    next();
    iptal = 1'b1; iptal_adres = 5'd4;
    next();
    gonder = 1'b1; rd_port(0, 4);
    settle();
    check("x4 squashed", 64'(durdur), 64'd0);
    check("x4 hata before", 64'(hata), 64'd0);
    next();
    iptal = 1'b1; iptal_adres = 5'd4;
    next();
    settle(); check("hata set", 64'(hata), 64'd1);
    next();
    settle(); check("hata sticky", 64'(hata), 64'd1);
    rst = 1'b1;
    next();
    settle(); check("hata cleared", 64'(hata), 64'd0);

    // Third read port hazard, then reset mid-run.
    gy(6, 32'h66);
    next();
    issue(6);
    next();
    gonder = 1'b1; rd_port(0, 1); rd_port(1, 2); rd_port(2, 6);
    settle(); check("port2 stall", 64'(durdur), 64'd1);
    next();
    gonder = 1'b1; rd_port(2, 6); rst = 1'b1;
    next();
    gonder = 1'b1; rd_port(2, 6);
    settle();
    check("post-rst stall", 64'(durdur), 64'd0);
    check("post-rst sayac", 64'(sayac), 64'd0);
    check("post-rst hata", 64'(hata), 64'd0);
    check("post-rst x6", 64'(oku_deger[95:64]), 64'd0);
    next();
    next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
